// File: rtl/square_arbiter.sv
// Round-robin arbiter that shares one 3-bit squarer among N_REQ requesters.
// Holds one registered result per response and counts completed responses.

module square (
    input  logic [2:0] num,
    output logic [5:0] square_num
);
    assign square_num = {3'b000, num} * {3'b000, num};
endmodule

module square_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [3*N_REQ-1:0] req_num,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [5:0]         rsp_square,
    input  logic               rsp_ready,
    output logic [7:0]         done_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic [IDW-1:0] ptr;
    logic        can_accept;
    logic        found;
    logic        transfer;
    int unsigned win_i;
    logic [2:0]  sq_in;
    logic [5:0]  sq_out;

    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign transfer   = found && can_accept;

    // Two passes give the rotated priority: first ptr..N_REQ-1, then 0..ptr-1.
    always_comb begin
        found = 1'b0;
        win_i = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && (i >= 32'(ptr)) && req_valid[i]) begin
                found = 1'b1;
                win_i = i;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win_i = i;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sq_in     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_i == i) begin
                req_ready[i] = rst_n && transfer;
                sq_in        = req_num[3*i +: 3];
            end
        end
    end

    square u_square (
        .num        (sq_in),
        .square_num (sq_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            rsp_id     <= '0;
            rsp_square <= '0;
            done_cnt   <= '0;
        end else begin
            if (transfer) begin
                state      <= FULL;
                rsp_square <= sq_out;
                rsp_id     <= IDW'(win_i);
                ptr        <= IDW'((win_i + 1) % N_REQ);
            end else if ((state == FULL) && rsp_ready) begin
                state <= EMPTY;
            end
            if ((state == FULL) && rsp_ready)
                done_cnt <= done_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_square_arbiter.sv
// Directed vector bench for square_arbiter with N_REQ=4.
// Table of per-cycle stimulus and expectations, plus reset and wrap sequences.

module tb_square_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDW   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [3*N_REQ-1:0]  req_num;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [5:0]          rsp_square;
    logic                rsp_ready;
    logic [7:0]          done_cnt;

    always #5 clk = ~clk;

    square_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_num    (req_num),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_square (rsp_square),
        .rsp_ready  (rsp_ready),
        .done_cnt   (done_cnt)
    );

    typedef struct {
        logic [3:0]  v;
        logic [11:0] num;
        logic        rdy;
        logic [3:0]  exp_rr;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [5:0]  exp_sq;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input int unsigned idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    function automatic logic [11:0] pk(input int unsigned n3, n2, n1, n0);
        return {3'(n3), 3'(n2), 3'(n1), 3'(n0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [11:0] num, input logic rdy,
                                input logic [3:0] rr, input logic val, input logic [1:0] id,
                                input logic [5:0] sq, input logic [7:0] cnt);
        vec_t t;
        t.v = v; t.num = num; t.rdy = rdy; t.exp_rr = rr;
        t.exp_valid = val; t.exp_id = id; t.exp_sq = sq; t.exp_cnt = cnt;
        return t;
    endfunction

    // Called at posedge+1: drive, check grant, then check registered result after the edge.
    task automatic apply(input vec_t t, input int unsigned idx);
        req_valid = t.v;
        req_num   = t.num;
        rsp_ready = t.rdy;
        #1;
        check("req_ready", idx, 32'(req_ready), 32'(t.exp_rr));
        @(posedge clk);
        #1;
        check("rsp_valid",  idx, 32'(rsp_valid),  32'(t.exp_valid));
        check("rsp_id",     idx, 32'(rsp_id),     32'(t.exp_id));
        check("rsp_square", idx, 32'(rsp_square), 32'(t.exp_sq));
        check("done_cnt",   idx, 32'(done_cnt),   32'(t.exp_cnt));
    endtask

    initial begin
        vecs.push_back(mk(4'b0001, pk(0,0,0,5), 1'b1, 4'b0001, 1'b1, 2'd0, 6'd25, 8'd0));
        vecs.push_back(mk(4'b0000, pk(0,0,0,5), 1'b1, 4'b0000, 1'b0, 2'd0, 6'd25, 8'd1));
        for (int unsigned k = 0; k < 8; k++)
            vecs.push_back(mk(4'b0100, pk(0,k,0,0), 1'b1, 4'b0100, 1'b1, 2'd2, 6'(k*k), 8'(k+1)));
        vecs.push_back(mk(4'b0000, pk(0,0,0,0), 1'b1, 4'b0000, 1'b0, 2'd2, 6'd49, 8'd9));
        vecs.push_back(mk(4'b0001, pk(0,0,0,3), 1'b1, 4'b0001, 1'b1, 2'd0, 6'd9,  8'd9));
        vecs.push_back(mk(4'b0011, pk(0,0,2,1), 1'b1, 4'b0010, 1'b1, 2'd1, 6'd4,  8'd10));
        vecs.push_back(mk(4'b0000, pk(0,0,0,0), 1'b1, 4'b0000, 1'b0, 2'd1, 6'd4,  8'd11));
        vecs.push_back(mk(4'b1000, pk(6,0,0,0), 1'b1, 4'b1000, 1'b1, 2'd3, 6'd36, 8'd11));
        vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b1, 4'b0001, 1'b1, 2'd0, 6'd1,  8'd12));
        vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b1, 4'b0010, 1'b1, 2'd1, 6'd4,  8'd13));
        vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b1, 4'b0100, 1'b1, 2'd2, 6'd9,  8'd14));
        vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b1, 4'b1000, 1'b1, 2'd3, 6'd16, 8'd15));
        vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b1, 4'b0001, 1'b1, 2'd0, 6'd1,  8'd16));
        for (int unsigned k = 0; k < 3; k++)
            vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b0, 4'b0000, 1'b1, 2'd0, 6'd1, 8'd16));
        vecs.push_back(mk(4'b1111, pk(4,3,2,1), 1'b1, 4'b0010, 1'b1, 2'd1, 6'd4,  8'd17));
        vecs.push_back(mk(4'b0000, pk(0,0,0,0), 1'b1, 4'b0000, 1'b0, 2'd1, 6'd4,  8'd18));
        vecs.push_back(mk(4'b0100, pk(0,3,0,0), 1'b0, 4'b0100, 1'b1, 2'd2, 6'd9,  8'd18));
        vecs.push_back(mk(4'b0000, pk(0,0,0,0), 1'b0, 4'b0000, 1'b1, 2'd2, 6'd9,  8'd18));
        vecs.push_back(mk(4'b0000, pk(0,0,0,0), 1'b1, 4'b0000, 1'b0, 2'd2, 6'd9,  8'd19));
        vecs.push_back(mk(4'b0001, pk(0,0,0,7), 1'b0, 4'b0001, 1'b1, 2'd0, 6'd49, 8'd19));

        // Reset: grant must be suppressed even with requests present.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_num   = pk(4,3,2,1);
        rsp_ready = 1'b1;
        #2;
        check("reset_req_ready",  0, 32'(req_ready),  32'd0);
        check("reset_rsp_valid",  0, 32'(rsp_valid),  32'd0);
        check("reset_rsp_id",     0, 32'(rsp_id),     32'd0);
        check("reset_rsp_square", 0, 32'(rsp_square), 32'd0);
        check("reset_done_cnt",   0, 32'(done_cnt),   32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i], i + 1);

        // Asynchronous reset while FULL; ptr was 1, so 0011 afterwards proves ptr cleared.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 0, 32'(req_ready), 32'd0);
        check("midrst_done_cnt",  0, 32'(done_cnt),  32'd0);
        check("midrst_rsp_sq",    0, 32'(rsp_square), 32'd0);
        req_valid = 4'b0011;
        req_num   = pk(0,0,2,7);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_req_ready", 0, 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("postrst_rsp_id",    0, 32'(rsp_id),     32'd0);
        check("postrst_rsp_sq",    0, 32'(rsp_square), 32'd49);
        check("postrst_done_cnt",  0, 32'(done_cnt),   32'd0);

        // Full-throughput run: one completion per edge from here on.
        req_valid = 4'b0001;
        for (int unsigned k = 0; k < 255; k++) begin
            @(posedge clk);
            #1;
        end
        check("wrap_cnt_255",   0, 32'(done_cnt),  32'd255);
        check("wrap_rsp_valid", 0, 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        check("wrap_cnt_0",     0, 32'(done_cnt),  32'd0);
        check("wrap_rsp_id",    0, 32'(rsp_id),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
